fu_complete_buffer: RTL

FU_COMPLETE_BUFFER -- requirements
Module: fu_complete_buffer

---
 rtl/fu_complete_buffer_pkg.sv | 37 +++
 rtl/fu_result_fifo.sv | 62 ++++++
 rtl/fu_complete_buffer.sv | 69 ++++++
 3 files changed

// File: rtl/fu_complete_buffer_pkg.sv
// Shared execute/complete definitions (sys_defs): FU result packet, per-lane state packet
// and the FU lane order. Lane 0 is alu_1, so alu_1 is the least-significant state bit.
package sys_defs;

    localparam int unsigned FU_NUM = 8;

    typedef enum logic [2:0] {
        FuAlu1    = 3'd0,
        FuAlu2    = 3'd1,
        FuAlu3    = 3'd2,
        FuMult1   = 3'd3,
        FuMult2   = 3'd4,
        FuBranch1 = 3'd5,
        FuLoad1   = 3'd6,
        FuStore1  = 3'd7
    } fu_lane_e;

    typedef struct packed {
        logic        valid;
        logic [4:0]  prs;
        logic [31:0] dest_value;
        logic [4:0]  rob_entry;
    } FU_COMPLETE_PACKET;

    // Field order is MSB-first, so the last field (alu_1) lands on bit 0.
    typedef struct packed {
        logic store_1;
        logic load_1;
        logic branch_1;
        logic mult_2;
        logic mult_1;
        logic alu_3;
        logic alu_2;
        logic alu_1;
    } FU_STATE_PACKET;

endpackage

// File: rtl/fu_result_fifo.sv
// Single-lane in-order result FIFO. Storage is not reset; the consumer masks by count.
module fu_result_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         pkt_t = logic
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  pkt_t                         din,
    output pkt_t                         head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    pkt_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr_q] <= din;
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fu_complete_buffer.sv
// Per-FU result buffering between the functional units and complete_stage: one FIFO per
// lane, head presented with valid forced on, squash flushing every lane at the next edge.
module fu_complete_buffer
    import sys_defs::*;
#(
    parameter int unsigned NUM_FU = FU_NUM,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                squash,
    input  logic [NUM_FU-1:0]                   fu_valid,
    input  FU_COMPLETE_PACKET [NUM_FU-1:0]      fu_pkts,
    output logic [NUM_FU-1:0]                   fu_ready,
    output FU_STATE_PACKET                      cs_fu_done_flags,
    output FU_COMPLETE_PACKET [NUM_FU-1:0]      cs_fu_complete_pkts,
    input  FU_STATE_PACKET                      cs_stall_mask,
    output logic [NUM_FU*$clog2(DEPTH+1)-1:0]   lane_count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [NUM_FU-1:0] stall_vec;
    logic [NUM_FU-1:0] done_vec;

    assign stall_vec        = cs_stall_mask;
    assign cs_fu_done_flags = done_vec;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_lane
        logic [CW-1:0]     count;
        logic              push;
        logic              pop;
        FU_COMPLETE_PACKET head;
        FU_COMPLETE_PACKET pkt_out;

        // Ready comes from the registered count only, so a full lane stays not-ready
        // even in a cycle where it pops.
        assign fu_ready[i] = (count < CW'(DEPTH));
        assign done_vec[i] = (count != '0);
        assign push        = fu_valid[i] & fu_ready[i];
        assign pop         = done_vec[i] & ~stall_vec[i];

        fu_result_fifo #(
            .DEPTH (DEPTH),
            .pkt_t (FU_COMPLETE_PACKET)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .clear (squash),
            .push  (push),
            .pop   (pop),
            .din   (fu_pkts[i]),
            .head  (head),
            .count (count)
        );

        always_comb begin
            pkt_out = '0;
            if (done_vec[i]) begin
                pkt_out       = head;
                pkt_out.valid = 1'b1;
            end
        end

        assign cs_fu_complete_pkts[i]  = pkt_out;
        assign lane_count[i*CW +: CW]  = count;
    end

endmodule
